serial_frame_feeder: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the 8-bit shift register's serial-load mode.
- Accepts a parallel word over a valid/ready handshake and emits it one bit per clock on a serial line with a bit-valid strobe.
- Marks the first and last bit of each frame.
- Optional inter-frame gap lets the downstream register finish its 8-bit collection and be sampled before the next frame starts.

---
 rtl/feeder_pkg.sv | 14 +
 rtl/feeder_shifter.sv | 37 +++
 rtl/serial_frame_feeder.sv | 152 +++++++++++++++
 tb/tb_serial_frame_feeder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and limits for the serial frame feeder.
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } feed_state_e;

    localparam int FEED_MAX_WIDTH = 16;
    localparam int FEED_MAX_GAP   = 15;
    localparam int FEED_GAP_W     = $clog2(FEED_MAX_GAP + 1);

endpackage

// File: rtl/feeder_shifter.sv
// WIDTH-bit load/shift register; exposes the bit currently on the serial line.
module feeder_shifter #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out
);

    logic [WIDTH-1:0] sh_q, sh_d;

    // Zeros shift in, so the register is empty once the last bit has left.
    always_comb begin
        sh_d = sh_q;
        if (clear) begin
            sh_d = '0;
        end else if (load) begin
            sh_d = load_data;
        end else if (shift) begin
            if (MSB_FIRST != 0) sh_d = {sh_q[WIDTH-2:0], 1'b0};
            else                sh_d = {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= sh_d;
    end

    assign bit_out = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];

endmodule

// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial frame feeder: valid/ready word in, one bit per clock out
// with first/last markers and an optional idle gap between frames.
//
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   SHIFT | emitting bit bit_idx of the current frame
//   GAP   | idle spacing after the last bit, in_ready low
module serial_frame_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     frame_start,
    output logic                     frame_last,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [FEED_GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? FEED_GAP_W'(GAP_CYCLES - 1) : '0;

    generate
        if (WIDTH < 2 || WIDTH > FEED_MAX_WIDTH || GAP_CYCLES < 0 || GAP_CYCLES > FEED_MAX_GAP) begin : g_bad_params
            $error("serial_frame_feeder: parameter out of range");
        end
    endgenerate

    feed_state_e           state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FEED_GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic ser_valid_q, ser_valid_d;
    logic frame_start_q, frame_start_d;
    logic frame_last_q, frame_last_d;
    logic busy_q, busy_d;
    logic sh_clear, sh_load, sh_shift;
    logic last_bit, xfer;

    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
    assign in_ready = !flush && ((state_q == IDLE) || ((GAP_CYCLES == 0) && last_bit));
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sh_clear  = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        if (flush) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            sh_clear  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                        sh_load   = 1'b1;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        bit_cnt_d = '0;
                        sh_load   = 1'b1;
                    end else if (bit_cnt_q == LAST_IDX) begin
                        bit_cnt_d = '0;
                        sh_shift  = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sh_shift  = 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) state_d   = IDLE;
                    else                 gap_cnt_d = gap_cnt_q - 1'b1;
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        ser_valid_d   = (state_d == SHIFT);
        frame_start_d = (state_d == SHIFT) && (bit_cnt_d == '0);
        frame_last_d  = (state_d == SHIFT) && (bit_cnt_d == LAST_IDX);
        busy_d        = (state_d != IDLE);
    end

    feeder_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (sh_clear),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_data (in_data),
        .bit_out   (ser_out)
    );

    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_last  = frame_last_q;
    assign busy        = busy_q;
    assign bit_idx     = bit_cnt_q;

endmodule

// File: tb/tb_serial_frame_feeder.sv
// Bench for serial_frame_feeder: default instance (MSB first, no gap) and an
// LSB-first instance with a 3-cycle gap, both checked against a frame-position model.
module tb_serial_frame_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] flush_v = '0;
    logic [1:0] valid_v = '0;
    logic [7:0] data0 = '0, data1 = '0;
    logic [1:0] ready_v, sout_v, sval_v, fst_v, flast_v, busy_v;
    logic [2:0] bidx0, bidx1;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: pos = -1 idle, 0..7 bit being sent, 8..8+gap-1 inside the gap.
    int         pos[2];
    logic [7:0] word[2];
    logic [7:0] col[2];
    bit         xfer[2];
    int         gapc[2];
    bit         msbf[2];

    always #5 clk = ~clk;

    serial_frame_feeder u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_v[0]), .in_data(data0),
        .in_valid(valid_v[0]), .in_ready(ready_v[0]), .ser_out(sout_v[0]),
        .ser_valid(sval_v[0]), .frame_start(fst_v[0]), .frame_last(flast_v[0]),
        .busy(busy_v[0]), .bit_idx(bidx0)
    );

    serial_frame_feeder #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_v[1]), .in_data(data1),
        .in_valid(valid_v[1]), .in_ready(ready_v[1]), .ser_out(sout_v[1]),
        .ser_valid(sval_v[1]), .frame_start(fst_v[1]), .frame_last(flast_v[1]),
        .busy(busy_v[1]), .bit_idx(bidx1)
    );

    task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic logic exp_ready(input int i);
        return !flush_v[i] && (pos[i] < 0 || (pos[i] == 7 && gapc[i] == 0));
    endfunction

    function automatic logic [7:0] in_word(input int i);
        return (i == 0) ? data0 : data1;
    endfunction

    task automatic set_in(input int i, input logic v, input logic [7:0] d);
        valid_v[i] = v;
        if (i == 0) data0 = d;
        else        data1 = d;
    endtask

    task automatic check_out(input int i);
        bit       v;
        int       k;
        logic     e_out;
        logic [2:0] obs_idx;
        v       = (pos[i] >= 0) && (pos[i] < 8);
        k       = msbf[i] ? 7 - pos[i] : pos[i];
        e_out   = v ? word[i][k] : 1'b0;
        obs_idx = (i == 0) ? bidx0 : bidx1;
        chk("ser_valid",   i, 8'(sval_v[i]),  8'(v));
        chk("ser_out",     i, 8'(sout_v[i]),  8'(e_out));
        chk("frame_start", i, 8'(fst_v[i]),   8'(pos[i] == 0));
        chk("frame_last",  i, 8'(flast_v[i]), 8'(pos[i] == 7));
        chk("busy",        i, 8'(busy_v[i]),  8'(pos[i] >= 0));
        chk("bit_idx",     i, 8'(obs_idx),    v ? 8'(pos[i]) : 8'd0);
        if (v) begin
            if (msbf[i]) col[i] = {col[i][6:0], sout_v[i]};
            else         col[i] = {sout_v[i], col[i][7:1]};
        end
        if (pos[i] == 7) chk("collected", i, col[i], word[i]);
    endtask

    task automatic cycle();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, 8'(ready_v[i]), 8'(exp_ready(i)));
            xfer[i] = exp_ready(i) && valid_v[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (flush_v[i]) begin
                pos[i] = -1;
            end else if (xfer[i]) begin
                word[i] = in_word(i);
                pos[i]  = 0;
            end else if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] >= 8 + gapc[i]) pos[i] = -1;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) check_out(i);
    endtask

    task automatic send_two(input int i, input logic [7:0] w0, input logic [7:0] w1, input int budget);
        int cnt;
        cnt = 0;
        set_in(i, 1'b1, w0);
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (xfer[i]) begin
                cnt++;
                if (cnt == 1) set_in(i, 1'b1, w1);
                else          set_in(i, 1'b0, 8'h00);
            end
        end
        chk("words_accepted", i, 8'(cnt), 8'd2);
    endtask

    initial begin
        pos  = '{-1, -1};
        word = '{8'h00, 8'h00};
        col  = '{8'h00, 8'h00};
        xfer = '{1'b0, 1'b0};
        gapc = '{0, 3};
        msbf = '{1'b1, 1'b0};

        // Reset values while rst_n is held low
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", i, 8'(ready_v[i]), 8'd1);
            check_out(i);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        // A5 MSB-first on the default instance
        set_in(0, 1'b1, 8'hA5);
        cycle();
        set_in(0, 1'b0, 8'h00);
        repeat (10) cycle();

        // 01 LSB-first on the gapped instance
        set_in(1, 1'b1, 8'h01);
        cycle();
        set_in(1, 1'b0, 8'h00);
        repeat (13) cycle();

        // Back-to-back F0 / 0F with no gap
        send_two(0, 8'hF0, 8'h0F, 20);

        // Two queued words through the 3-cycle gap
        send_two(1, 8'h3C, 8'hC6, 30);

        // Flush at bit 4 of FF with 55 offered at the same time
        set_in(0, 1'b1, 8'hFF);
        cycle();
        set_in(0, 1'b0, 8'h00);
        repeat (4) cycle();
        flush_v[0] = 1'b1;
        set_in(0, 1'b1, 8'h55);
        cycle();
        flush_v[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (xfer[0]) set_in(0, 1'b0, 8'h00);
        end

        // Asynchronous reset at bit 2 on both instances
        set_in(0, 1'b1, 8'h9B);
        set_in(1, 1'b1, 8'h6D);
        cycle();
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        repeat (2) cycle();
        rst_n = 1'b0;
        #2;
        pos = '{-1, -1};
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_in_ready", i, 8'(ready_v[i]), 8'd1);
            check_out(i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) cycle();

        // Randomized traffic with occasional flush
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                flush_v[i] = ($urandom_range(0, 24) == 0);
                set_in(i, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
            end
            cycle();
        end
        flush_v = '0;
        valid_v = '0;
        repeat (15) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
